// File: rtl/bop_pkg.sv
// Shared types and constants for the buffer overflow protection path.
// Used by the interval tracker and the interval store.
package bop_pkg;

  localparam int BOP_ADDR_W        = 32;
  localparam int BOP_DEPTH_DEFAULT = 8;
  localparam int BOP_WRITE_SIZE    = 16;
  localparam int BOP_DATE_MAX      = 6;

  typedef struct packed {
    logic [BOP_ADDR_W-1:0] first;
    logic [BOP_ADDR_W-1:0] last;
    logic                  valid;
  } bop_interval_t;

endpackage

// File: rtl/bop_interval_match.sv
// Combinational matcher over the interval array.
// Range mode checks containment; equality mode checks an exact {first,last}.
module bop_interval_match
  import bop_pkg::*;
#(
  parameter int unsigned DEPTH = BOP_DEPTH_DEFAULT,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  bop_interval_t          entries_i [DEPTH],
  input  logic                   eq_mode_i,
  input  logic [BOP_ADDR_W-1:0]  addr_i,
  input  logic [BOP_ADDR_W-1:0]  key_last_i,
  output logic [DEPTH-1:0]       hit_o,
  output logic [DEPTH-1:0]       first_o,
  output logic [IDX_W-1:0]       idx_o
);

  always_comb begin
    hit_o   = '0;
    first_o = '0;
    idx_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eq_mode_i) begin
        hit_o[i] = entries_i[i].valid
                 && (entries_i[i].first == addr_i)
                 && (entries_i[i].last == key_last_i);
      end else begin
        hit_o[i] = entries_i[i].valid
                 && (entries_i[i].first <= addr_i)
                 && (addr_i <= entries_i[i].last);
      end
      first_o[i] = hit_o[i] && (entries_i[i].first == addr_i);
    end
    // Descending scan so the lowest hitting index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bop_interval_store.sv
// Registered, flushable circular store of completed store intervals
// with a one-cycle pipelined address lookup and overflow reporting.
module bop_interval_store
  import bop_pkg::*;
#(
  parameter int unsigned DEPTH  = BOP_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = BOP_ADDR_W,
  parameter bit          DEDUP  = 1'b1,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_first_i,
  input  logic [ADDR_W-1:0] wr_last_i,
  output logic              wr_err_o,
  input  logic              query_valid_i,
  input  logic [ADDR_W-1:0] query_addr_i,
  output logic              query_valid_o,
  output logic              query_hit_o,
  output logic              query_is_first_o,
  output logic [IDX_W-1:0]  query_index_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              overflow_o
);

  logic [BOP_ADDR_W-1:0] first_q [DEPTH];
  logic [BOP_ADDR_W-1:0] last_q  [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  qv_q, qhit_q, qfirst_q;
  logic [IDX_W-1:0]      qidx_q;

  bop_interval_t         ents [DEPTH];
  logic [BOP_ADDR_W-1:0] wr_first_w, wr_last_w, q_addr_w;
  logic [DEPTH-1:0]      q_hit_vec, q_first_vec;
  logic [DEPTH-1:0]      dd_hit_vec, dd_first_vec;
  logic [IDX_W-1:0]      q_idx, dd_idx;
  logic                  do_wr, bad, dup, store;

  assign wr_first_w = BOP_ADDR_W'(wr_first_i);
  assign wr_last_w  = BOP_ADDR_W'(wr_last_i);
  assign q_addr_w   = BOP_ADDR_W'(query_addr_i);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ents[i].first = first_q[i];
      ents[i].last  = last_q[i];
      ents[i].valid = valid_q[i];
    end
  end

  bop_interval_match #(.DEPTH(DEPTH)) u_query (
    .entries_i  (ents),
    .eq_mode_i  (1'b0),
    .addr_i     (q_addr_w),
    .key_last_i ('0),
    .hit_o      (q_hit_vec),
    .first_o    (q_first_vec),
    .idx_o      (q_idx)
  );

  bop_interval_match #(.DEPTH(DEPTH)) u_dedup (
    .entries_i  (ents),
    .eq_mode_i  (1'b1),
    .addr_i     (wr_first_w),
    .key_last_i (wr_last_w),
    .hit_o      (dd_hit_vec),
    .first_o    (dd_first_vec),
    .idx_o      (dd_idx)
  );

  // The lowest hitting index is itself a hit whenever any entry matches.
  assign dup   = DEDUP && dd_hit_vec[dd_idx] && dd_first_vec[dd_idx];
  assign do_wr = wr_en_i && !flush_i;
  assign bad   = wr_first_i > wr_last_i;
  assign store = do_wr && !bad && !dup;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = do_wr && bad;
    if (flush_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (store) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (valid_q[wr_ptr_q]) ovf_d = 1'b1;
      else count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      first_q[wr_ptr_q] <= wr_first_w;
      last_q[wr_ptr_q]  <= wr_last_w;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qv_q     <= 1'b0;
      qhit_q   <= 1'b0;
      qfirst_q <= 1'b0;
      qidx_q   <= '0;
    end else begin
      qv_q <= query_valid_i;
      if (query_valid_i) begin
        qhit_q   <= |q_hit_vec;
        qfirst_q <= |q_first_vec;
        qidx_q   <= q_idx;
      end
    end
  end

  assign wr_err_o         = err_q;
  assign query_valid_o    = qv_q;
  assign query_hit_o      = qhit_q;
  assign query_is_first_o = qfirst_q;
  assign query_index_o    = qidx_q;
  assign count_o          = count_q;
  assign full_o           = count_q == CNT_W'(DEPTH);
  assign overflow_o       = ovf_q;

endmodule

// File: doc/bop_interval_store.md
Name: bop_interval_store

Overview:
- Storage and lookup side of the Buffer Overflow Protection path.
- The interval tracker pushes completed store intervals {first, last} into this block.
- Load/store checkers query an address and get back hit, is-first and hit index one cycle later.
- Replaces the ad-hoc combinational interval buffer with a registered, flushable, overflow-reporting circular store.

Parameters:
- DEPTH, 8, number of interval entries (power of two, ≥2).
- ADDR_W, 32, address width.
- DEDUP, 1, when 1 an exact duplicate {first,last} already valid is not re-inserted.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- flush_i  input  1  synchronous clear of all entries.
- wr_en_i  input  1  one-cycle write strobe for a new interval.
- wr_first_i  input  ADDR_W  interval start address (inclusive).
- wr_last_i  input  ADDR_W  interval end address (inclusive).
- wr_err_o  output  1  pulse: write rejected because first > last.
- query_valid_i  input  1  query request.
- query_addr_i  input  ADDR_W  address to check.
- query_valid_o  output  1  query result valid, 1 cycle after query_valid_i.
- query_hit_o  output  1  address lies in some valid interval.
- query_is_first_o  output  1  address equals first of a hitting interval.
- query_index_o  output  $clog2(DEPTH)  lowest-index hitting entry (0 if no hit).
- count_o  output  $clog2(DEPTH)+1  number of valid entries.
- full_o  output  1  count_o == DEPTH.
- overflow_o  output  1  sticky: a valid entry was overwritten.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - All valid bits, wr_ptr and count cleared.
  - overflow_o, wr_err_o, query_valid_o, query_hit_o, query_is_first_o and query_index_o all 0.
  - Entry address contents need no reset.
- Reset mid-query: the in-flight result is discarded; query_valid_o is 0 on the first cycle after reset release.
- Write, evaluated at the clock edge when wr_en_i=1 and flush_i=0:
  - first > last (unsigned): nothing stored; wr_err_o=1 for exactly one cycle.
  - DEDUP=1 and a valid entry equals {first,last}: nothing stored, no error, pointer and count unchanged.
  - Otherwise: entry[wr_ptr] <= {first,last,valid=1}; wr_ptr <= wr_ptr+1 (wraps DEPTH-1→0).
  - If entry[wr_ptr] was already valid: count unchanged, overflow_o set (sticky until flush or reset).
  - Else count increments.
  - A single-address interval (first == last) is legal.
- Flush (flush_i=1):
  - Next cycle: all valid=0, wr_ptr=0, count=0, overflow_o=0.
  - A wr_en_i in the same cycle is dropped (flush wins), and no wr_err_o is raised.
  - A query issued in the flush cycle returns results from the pre-flush contents.
- Query:
  - Registered, latency 1, fully pipelined: one query per cycle, no backpressure.
  - Result cycle N+1 reflects contents as they stood in cycle N. A write in cycle N is not visible to a query in cycle N; it is visible from cycle N+1.
  - Hit for entry i: valid[i] && first[i] <= addr && addr <= last[i] (unsigned, inclusive both ends).
  - query_hit_o is the OR over all entries; query_index_o is the lowest i with a hit.
  - query_is_first_o = 1 if any hitting entry has addr == first[i], not just the indexed one.
  - When query_valid_i=0: query_valid_o=0 next cycle; the other query outputs hold their last value and are don't-care.
- No arithmetic wrap: intervals are never required to cross 2^ADDR_W; the comparison stays plain unsigned.
- count_o, full_o and overflow_o are registered and update the cycle after the causing write or flush.

Decomposition:
- bop_pkg holds:
  - bop_interval_t struct {logic [ADDR_W-1:0] first; logic [ADDR_W-1:0] last; logic valid;}
  - BOP_DEPTH_DEFAULT = 8
  - BOP_WRITE_SIZE = 16 and BOP_DATE_MAX = 6, shared with the interval tracker.
- Sub-module bop_interval_match:
  - Purely combinational.
  - Takes the entry array and an address; returns hit vector, first vector, lowest-hit index.
  - Instanced once for the query path.
  - Reused with an equality mode for the DEDUP check.

Test Plan:
1. Reset, write {0x1000,0x1013}, query 0x1000/0x1008/0x1013/0x1014 -> hit=1/1/1/0, is_first=1/0/0/0, index=0, count=1.
2. Write {0x2000,0x1FFF} -> wr_err_o pulses once, count stays 0; write {0x3000,0x3000}, query 0x3000 -> hit=1, is_first=1.
3. DEPTH=8: write 9 distinct intervals {0x100*k, 0x100*k+0x20}, k=1..9 -> full_o=1 after the 8th; after the 9th, overflow_o=1, count=8, query 0x110 misses, query 0x910 hits at index 0.
4. Write {0x4000,0x4020} twice with DEDUP=1 -> count=1, wr_ptr=1; overlapping {0x4010,0x4030} stored at index 1; query 0x4010 -> index 0, is_first=1.
5. Same-cycle write {0x5000,0x5010} and query 0x5005 -> result miss; query 0x5005 next cycle -> hit.
6. Flush with simultaneous wr_en_i and query 0x1000 (entry present) -> query hits; next cycle count=0, overflow_o=0, a later query of 0x1000 misses. Assert rst_i mid-query -> query_valid_o=0 after release.
